// File: rtl/save_ram_responder.sv
// save_ram_responder: memory-side endpoint of the APF save RAM bus.
// Owns the cartridge battery SRAM (single-port, byte-enabled 16-bit RAM),
// arbitrates between the save bus and the 68k cartridge bus, fills the RAM
// with 16'hFFFF on each new cartridge download, and keeps a sticky dirty flag.
module save_ram_responder #(
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  bk_wr,
    input  logic [16:0]           bk_addr,
    input  logic [15:0]           bk_data,
    output logic [15:0]           bk_q,
    input  logic                  cart_download,
    input  logic                  cart_req,
    input  logic                  cart_we,
    input  logic [1:0]            cart_be,
    input  logic [ADDR_WIDTH-1:0] cart_addr,
    input  logic [15:0]           cart_wdata,
    output logic                  cart_ack,
    output logic [15:0]           cart_rdata,
    input  logic                  dirty_clr,
    output logic                  save_dirty,
    output logic                  busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic S_IDLE  = 1'b0;
    localparam logic S_CLEAR = 1'b1;

    logic [15:0]           r_mem [0:DEPTH-1];
    logic [15:0]           r_ram_q;

    logic                  r_state;
    logic [ADDR_WIDTH-1:0] r_clr_addr;
    logic                  r_bk_wr_d;
    logic                  r_dl_d;

    logic                  r_bk_pend;
    logic [ADDR_WIDTH-1:0] r_bk_paddr;
    logic [15:0]           r_bk_pdata;

    logic                  r_cart_pend;
    logic                  r_c_we;
    logic [1:0]            r_c_be;
    logic [ADDR_WIDTH-1:0] r_c_addr;
    logic [15:0]           r_c_wdata;

    logic                  r_last_cart;
    logic                  r_bkr_v;
    logic                  r_cart_rd_v;
    logic [15:0]           r_cart_hold;

    logic                  w_bk_rise;
    logic                  w_dl_rise;
    logic                  w_idle;
    logic                  w_g_bkw;
    logic                  w_g_cart;
    logic                  w_g_bkr;
    logic                  w_g_clr;
    logic                  w_ram_we;
    logic                  w_ram_re;
    logic [1:0]            w_ram_be;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic [15:0]           w_ram_wdata;
    logic                  w_unused_bk_addr;

    assign w_unused_bk_addr = ^bk_addr[16:ADDR_WIDTH];

    // Grant selection and RAM port multiplexing: one access per cycle
    always_comb begin
        w_bk_rise   = bk_wr & ~r_bk_wr_d;
        w_dl_rise   = cart_download & ~r_dl_d;
        w_idle      = (r_state == S_IDLE) && !w_dl_rise && !reset;
        w_g_bkw     = w_idle && r_bk_pend;
        // A cart grant yields to a bk read refresh right after another cart grant
        w_g_cart    = w_idle && !r_bk_pend && r_cart_pend && !r_last_cart;
        w_g_bkr     = w_idle && !r_bk_pend && !w_g_cart;
        w_g_clr     = (r_state == S_CLEAR) && !reset;

        w_ram_we    = w_g_clr | w_g_bkw | (w_g_cart & r_c_we);
        w_ram_re    = w_g_bkr | (w_g_cart & ~r_c_we);
        w_ram_be    = w_g_cart ? r_c_be : 2'b11;
        w_ram_addr  = bk_addr[ADDR_WIDTH-1:0];
        w_ram_wdata = r_c_wdata;
        if (w_g_clr) begin
            w_ram_addr  = r_clr_addr;
            w_ram_wdata = 16'hFFFF;
        end else if (w_g_bkw) begin
            w_ram_addr  = r_bk_paddr;
            w_ram_wdata = r_bk_pdata;
        end else if (w_g_cart) begin
            w_ram_addr  = r_c_addr;
        end
    end

    // Byte-enabled RAM with a single registered read port; contents survive reset
    always_ff @(posedge clk_sys) begin
        if (w_ram_we) begin
            if (w_ram_be[0]) r_mem[w_ram_addr][7:0]  <= w_ram_wdata[7:0];
            if (w_ram_be[1]) r_mem[w_ram_addr][15:8] <= w_ram_wdata[15:8];
        end
        if (w_ram_re) r_ram_q <= r_mem[w_ram_addr];
    end

    // Request capture, completion tracking, dirty flag and clear sweep sequencing
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_clr_addr  <= '0;
            r_bk_wr_d   <= 1'b0;
            r_dl_d      <= 1'b0;
            r_bk_pend   <= 1'b0;
            r_bk_paddr  <= '0;
            r_bk_pdata  <= '0;
            r_cart_pend <= 1'b0;
            r_c_we      <= 1'b0;
            r_c_be      <= '0;
            r_c_addr    <= '0;
            r_c_wdata   <= '0;
            r_last_cart <= 1'b0;
            r_bkr_v     <= 1'b0;
            r_cart_rd_v <= 1'b0;
            r_cart_hold <= '0;
            bk_q        <= '0;
            cart_ack    <= 1'b0;
            save_dirty  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            r_bk_wr_d <= bk_wr;
            r_dl_d    <= cart_download;

            if (w_g_bkw) r_bk_pend <= 1'b0;
            if (w_bk_rise) begin
                r_bk_pend  <= 1'b1;
                r_bk_paddr <= bk_addr[ADDR_WIDTH-1:0];
                r_bk_pdata <= bk_data;
            end

            if (w_g_cart) begin
                r_cart_pend <= 1'b0;
            end else if (cart_req && !r_cart_pend) begin
                r_cart_pend <= 1'b1;
                r_c_we      <= cart_we;
                r_c_be      <= cart_be;
                r_c_addr    <= cart_addr;
                r_c_wdata   <= cart_wdata;
            end

            if (w_g_bkw || w_g_cart || w_g_bkr) r_last_cart <= w_g_cart;

            cart_ack    <= w_g_cart;
            r_cart_rd_v <= w_g_cart & ~r_c_we;
            if (r_cart_rd_v) r_cart_hold <= r_ram_q;

            r_bkr_v <= w_g_bkr;
            if (r_bkr_v) bk_q <= r_ram_q;

            if (r_state == S_CLEAR)         save_dirty <= 1'b0;
            else if (w_g_cart && r_c_we)    save_dirty <= 1'b1;
            else if (dirty_clr)             save_dirty <= 1'b0;

            if (w_dl_rise) begin
                r_state    <= S_CLEAR;
                r_clr_addr <= '0;
                busy       <= 1'b1;
            end else if (r_state == S_CLEAR) begin
                r_clr_addr <= r_clr_addr + 1'b1;
                if (r_clr_addr == '1) begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            end
        end
    end

    // Cart read data comes straight off the RAM output register in the ack
    // cycle and is held from a copy afterwards, keeping a single read port.
    assign cart_rdata = r_cart_rd_v ? r_ram_q : r_cart_hold;

endmodule

// File: tb/tb_save_ram_responder.sv
// Directed testbench for save_ram_responder with ADDR_WIDTH = 4.
module tb_save_ram_responder;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        bk_wr;
    logic [16:0] bk_addr;
    logic [15:0] bk_data;
    logic [15:0] bk_q;
    logic        cart_download;
    logic        cart_req;
    logic        cart_we;
    logic [1:0]  cart_be;
    logic [3:0]  cart_addr;
    logic [15:0] cart_wdata;
    logic        cart_ack;
    logic [15:0] cart_rdata;
    logic        dirty_clr;
    logic        save_dirty;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    save_ram_responder #(.ADDR_WIDTH(4)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .bk_wr        (bk_wr),
        .bk_addr      (bk_addr),
        .bk_data      (bk_data),
        .bk_q         (bk_q),
        .cart_download(cart_download),
        .cart_req     (cart_req),
        .cart_we      (cart_we),
        .cart_be      (cart_be),
        .cart_addr    (cart_addr),
        .cart_wdata   (cart_wdata),
        .cart_ack     (cart_ack),
        .cart_rdata   (cart_rdata),
        .dirty_clr    (dirty_clr),
        .save_dirty   (save_dirty),
        .busy         (busy)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one cart op right after a negedge; returns ack latency in cycles and read data
    task automatic cart_op(input logic we, input logic [1:0] be, input logic [3:0] addr,
                           input logic [15:0] wd, output int lat, output logic [15:0] rd);
        cart_req   = 1'b1;
        cart_we    = we;
        cart_be    = be;
        cart_addr  = addr;
        cart_wdata = wd;
        @(negedge clk_sys);
        cart_req = 1'b0;
        lat = 1;
        while (!cart_ack && lat < 20) begin
            @(negedge clk_sys);
            lat++;
        end
        rd = cart_rdata;
    endtask

    // Present a bk address, let the refresh settle, return bk_q
    task automatic bk_read(input logic [16:0] addr, output logic [15:0] q);
        bk_addr = addr;
        repeat (6) @(negedge clk_sys);
        q = bk_q;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk_sys);
        checks++;
        if (bk_q !== 16'h0 || cart_rdata !== 16'h0 || cart_ack !== 1'b0 ||
            save_dirty !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset: bk_q=%h cart_rdata=%h ack=%b dirty=%b busy=%b, required all zero",
                     bk_q, cart_rdata, cart_ack, save_dirty, busy);
        end
        reset = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic test_clear;
        int cnt;
        logic [15:0] q;
        int bad;
        cart_download = 1'b1;
        @(negedge clk_sys);
        cart_download = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL clear_busy_rise: busy=%b, required 1 one cycle after download edge", busy);
        end
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk_sys);
        end
        checks++;
        if (cnt != 16) begin
            failures++;
            $display("FAIL clear_busy_len: busy cycles=%0d, required 16", cnt);
        end
        bad = 0;
        for (int a = 0; a < 16; a++) begin
            bk_read(17'(a), q);
            if (q !== 16'hFFFF) begin
                bad++;
                $display("FAIL clear_fill addr %0d: bk_q=%h, required ffff", a, q);
            end
        end
        checks++;
        if (bad != 0) failures++;
        checks++;
        if (save_dirty !== 1'b0) begin
            failures++;
            $display("FAIL clear_dirty: save_dirty=%b, required 0", save_dirty);
        end
    endtask

    task automatic test_bk_write;
        logic [15:0] q;
        bk_addr = 17'd5;
        bk_data = 16'h1234;
        bk_wr   = 1'b1;
        @(negedge clk_sys);
        bk_data = 16'h5555;
        repeat (2) @(negedge clk_sys);
        bk_wr = 1'b0;
        bk_read(17'd5, q);
        checks++;
        if (q !== 16'h1234) begin
            failures++;
            $display("FAIL bk_write: bk_q=%h, required 1234", q);
        end
        checks++;
        if (save_dirty !== 1'b0) begin
            failures++;
            $display("FAIL bk_write_dirty: save_dirty=%b, required 0", save_dirty);
        end
    endtask

    task automatic test_cart_write;
        int lat;
        logic [15:0] rd;
        cart_op(1'b1, 2'b01, 4'd5, 16'hABCD, lat, rd);
        checks++;
        if (lat != 2) begin
            failures++;
            $display("FAIL cart_write_lat: ack after %0d cycles, required 2", lat);
        end
        checks++;
        if (save_dirty !== 1'b1) begin
            failures++;
            $display("FAIL cart_write_dirty: save_dirty=%b, required 1", save_dirty);
        end
        @(negedge clk_sys);
        cart_op(1'b0, 2'b11, 4'd5, 16'h0000, lat, rd);
        checks++;
        if (lat >= 20 || rd !== 16'h12CD) begin
            failures++;
            $display("FAIL cart_read_merge: rdata=%h lat=%0d, required 12cd", rd, lat);
        end
        repeat (2) @(negedge clk_sys);
        checks++;
        if (cart_ack !== 1'b0 || cart_rdata !== 16'h12CD) begin
            failures++;
            $display("FAIL cart_rdata_hold: ack=%b rdata=%h, required 0/12cd", cart_ack, cart_rdata);
        end
    endtask

    task automatic test_dirty_clr;
        dirty_clr = 1'b1;
        @(negedge clk_sys);
        dirty_clr = 1'b0;
        checks++;
        if (save_dirty !== 1'b0) begin
            failures++;
            $display("FAIL dirty_clr_first: save_dirty=%b, required 0", save_dirty);
        end
        cart_req   = 1'b1;
        cart_we    = 1'b1;
        cart_be    = 2'b11;
        cart_addr  = 4'd7;
        cart_wdata = 16'h0BEE;
        @(negedge clk_sys);
        cart_req  = 1'b0;
        dirty_clr = 1'b1;
        @(negedge clk_sys);
        dirty_clr = 1'b0;
        checks++;
        if (cart_ack !== 1'b1 || save_dirty !== 1'b1) begin
            failures++;
            $display("FAIL dirty_set_wins: ack=%b dirty=%b, required 1/1", cart_ack, save_dirty);
        end
        dirty_clr = 1'b1;
        @(negedge clk_sys);
        dirty_clr = 1'b0;
        checks++;
        if (save_dirty !== 1'b0) begin
            failures++;
            $display("FAIL dirty_clr_alone: save_dirty=%b, required 0", save_dirty);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [15:0] rd;
        int seen;
        int bad;
        logic [15:0] q;
        bk_read(17'd3, q);
        cart_op(1'b1, 2'b11, 4'd3, 16'h3333, lat, rd);
        seen = 0;
        bad  = 0;
        fork
            begin
                for (int n = 0; n < 4; n++) begin
                    cart_op(1'b0, 2'b11, 4'd5, 16'h0000, lat, rd);
                    if (lat > 4 || rd !== 16'h12CD) begin
                        bad++;
                        $display("FAIL b2b_read %0d: lat=%0d rdata=%h, required <=4/12cd", n, lat, rd);
                    end
                end
            end
            begin
                for (int c = 1; c <= 5; c++) begin
                    @(negedge clk_sys);
                    if (seen == 0 && bk_q === 16'h3333) seen = c;
                end
            end
        join
        checks++;
        if (bad != 0) failures++;
        checks++;
        if (seen == 0) begin
            failures++;
            $display("FAIL b2b_bk_refresh: bk_q=%h, required 3333 within 5 cycles", bk_q);
        end
    endtask

    task automatic test_restart;
        int cnt;
        int ack_busy;
        int dirty_busy;
        int lat;
        logic [15:0] rd;
        logic [15:0] q;
        cart_download = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_sys);
            if (k == 1) cart_download = 1'b0;
            if (k == 3) begin
                cart_req   = 1'b1;
                cart_we    = 1'b1;
                cart_be    = 2'b11;
                cart_addr  = 4'd2;
                cart_wdata = 16'h2222;
            end
            if (k == 4) cart_req = 1'b0;
            if (k == 10) cart_download = 1'b1;
        end
        @(negedge clk_sys);
        cart_download = 1'b0;
        cnt = 0;
        ack_busy = 0;
        dirty_busy = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            if (cart_ack !== 1'b0) ack_busy++;
            if (save_dirty !== 1'b0) dirty_busy++;
            @(negedge clk_sys);
        end
        checks++;
        if (cnt != 16) begin
            failures++;
            $display("FAIL restart_busy_len: busy cycles after restart=%0d, required 16", cnt);
        end
        checks++;
        if (ack_busy != 0 || dirty_busy != 0) begin
            failures++;
            $display("FAIL restart_held: ack cycles=%0d dirty cycles=%0d during sweep, required 0/0",
                     ack_busy, dirty_busy);
        end
        lat = 0;
        while (cart_ack !== 1'b1 && lat < 6) begin
            @(negedge clk_sys);
            lat++;
        end
        checks++;
        if (cart_ack !== 1'b1) begin
            failures++;
            $display("FAIL restart_ack: no ack within 6 cycles after busy fell");
        end
        checks++;
        if (save_dirty !== 1'b1) begin
            failures++;
            $display("FAIL restart_dirty: save_dirty=%b, required 1", save_dirty);
        end
        @(negedge clk_sys);
        cart_op(1'b0, 2'b11, 4'd2, 16'h0000, lat, rd);
        checks++;
        if (lat >= 20 || rd !== 16'h2222) begin
            failures++;
            $display("FAIL restart_readback: rdata=%h lat=%0d, required 2222", rd, lat);
        end
        bk_read(17'd5, q);
        checks++;
        if (q !== 16'hFFFF) begin
            failures++;
            $display("FAIL restart_cleared: bk_q at 5=%h, required ffff", q);
        end
        bk_read(17'h10002, q);
        checks++;
        if (q !== 16'h2222) begin
            failures++;
            $display("FAIL bk_upper_bits: bk_q=%h, required 2222", q);
        end
    endtask

    initial begin
        reset         = 1'b1;
        bk_wr         = 1'b0;
        bk_addr       = '0;
        bk_data       = '0;
        cart_download = 1'b0;
        cart_req      = 1'b0;
        cart_we       = 1'b0;
        cart_be       = '0;
        cart_addr     = '0;
        cart_wdata    = '0;
        dirty_clr     = 1'b0;
        @(negedge clk_sys);
        test_reset;
        test_clear;
        test_bk_write;
        test_cart_write;
        test_dirty_clr;
        test_back_to_back;
        test_restart;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
